wave_shaper: RTL and testbench
==============================

# wave_shaper

Parametrised multi-channel waveform shaper for the audio synthesis datapath. It converts per-channel phase accumulator values into signed waveform samples, selecting square with programmable duty, sawtooth, or triangle per channel. It sits between the phase accumulators and the mixer, and is fully pipelined with a configurable latency to stay aligned with the other generators.

## Interface
- N_CH, 4: number of channels.
- PHASE_W, 24: phase width, unsigned.
- OUT_W, 21: sample width, two's complement.
- AMP_SHIFT, 16: peak amplitude is 2^AMP_SHIFT. Legal only if AMP_SHIFT+2 <= OUT_W and AMP_SHIFT <= PHASE_W-2.
- LATENCY, 7: cycles from in_valid to out_valid. Legal range is 2 or more.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample strobe; may be high every cycle.
- phase  in  N_CH*PHASE_W  channel k at bits [k*PHASE_W +: PHASE_W].
- duty  in  N_CH*PHASE_W  square threshold per channel, same packing.
- mode  in  N_CH*2  per channel: 0 = square, 1 = saw, 2 = triangle, 3 = reserved.
- wave  out  N_CH*OUT_W  signed samples, channel k at bits [k*OUT_W +: OUT_W].
- out_valid  out  1  one-cycle strobe marking a new wave.

## Operation
- Stage 1, on an in_valid cycle: each lane computes its sample from phase, duty and mode sampled that cycle, then registers the sample together with a valid bit.
- Stages 2..LATENCY-1: a delay line carries the samples and valid bits.
- Output stage: wave loads only when the delay line's valid bit is set; otherwise wave holds its value.
- out_valid is that stage's valid bit, registered.
- Samples are independent per in_valid, so back-to-back inputs yield back-to-back outputs in order.
- Square mode: +2^AMP_SHIFT if phase <= duty, else -2^AMP_SHIFT.
  - duty = 0: high only at phase 0.
  - duty = all-ones: always high.
- Saw mode: (phase - 2^(PHASE_W-1)) arithmetic-shifted right by PHASE_W-1-AMP_SHIFT. Range is [-2^AMP_SHIFT, 2^AMP_SHIFT-1], and the sample wraps at the phase rollover.
- Triangle mode:
  - t = phase[PHASE_W-2:0] if the phase MSB is 0, else the bitwise inverse of phase[PHASE_W-2:0].
  - Output = (t >> (PHASE_W-2-AMP_SHIFT)) - 2^AMP_SHIFT. Range is identical to saw.
- Mode 3 (reserved): the sample is 0.
- All results are sign-extended to OUT_W; no saturation is needed within the legal parameter range.

## Timing
- Reset: wave = 0, out_valid = 0, all pipeline valid bits = 0.
  - Reset mid-operation discards every in-flight sample.
  - The first out_valid after reset comes no earlier than LATENCY cycles after the first post-reset in_valid.
- in_valid high at cycle c: out_valid is high at cycle c+LATENCY, with the matching wave visible in the same cycle.
- in_valid asserted together with rst is ignored.
- No backpressure: the consumer must accept every out_valid.
- wave is stable between out_valid strobes.

## Configuration
- WAVE_SHAPER_TRI_EN defined: triangle mode is implemented as above.
- WAVE_SHAPER_TRI_EN undefined: the triangle logic is removed and mode 2 behaves as mode 3 (sample 0). Square and saw are unchanged.

## Structure
- Shared package wave_pkg holds:
  - the mode encodings MODE_SQUARE, MODE_SAW, MODE_TRI, MODE_RSVD;
  - the mode field width, 2.
- Sub-module wave_shaper_lane: one channel's mode decode plus the stage-1 register, instantiated N_CH times.
- The top level owns the valid shift register, the sample delay line and the output registers.

## Test plan
All scenarios use default parameters.
- Square, duty 0x800000: phase 0x800000 -> 0x010000; phase 0x800001 -> 0x1F0000. out_valid rises exactly 7 cycles after in_valid.
- Saw, ch0: phase 0x000000 -> 0x1F0000 (-65536); 0x800000 -> 0x000000; 0xFFFFFF -> 0x00FFFF.
- Triangle, ch1: phase 0x000000 -> -65536; 0x400000 -> 0; 0x7FFFFF -> 65535; 0xFFFFFF -> -65536. With the macro undefined, all four -> 0.
- in_valid high for 10 consecutive cycles on a saw ramp: 10 consecutive out_valid strobes starting 7 cycles after the first input, with values in order.
- rst pulsed 3 cycles after an in_valid: no out_valid appears, and wave reads 0 until a post-reset sample arrives.
- Mixed modes on ch0–ch3 (square with duty 0, saw, triangle, mode 3), all phases 0: wave = {0, -65536, -65536, +65536}, listed ch3 down to ch0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform shaper: per-channel mode encodings.
package wave_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

endpackage

// File: rtl/wave_shaper_if.sv
// Sample bus between the phase accumulators, the waveform shaper and the mixer.
interface wave_shaper_if #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 21
);
    import wave_pkg::*;

    logic                      in_valid;
    logic [N_CH*PHASE_W-1:0]   phase;
    logic [N_CH*PHASE_W-1:0]   duty;
    logic [N_CH*MODE_W-1:0]    mode;
    logic [N_CH*OUT_W-1:0]     wave;
    logic                      out_valid;

    modport master (
        output in_valid, phase, duty, mode,
        input  wave, out_valid
    );

    modport slave (
        input  in_valid, phase, duty, mode,
        output wave, out_valid
    );

endinterface

// File: rtl/wave_shaper_lane.sv
// One channel of the waveform shaper: mode decode and the stage-1 sample register.
// Triangle support is compiled in only when WAVE_SHAPER_TRI_EN is defined.
module wave_shaper_lane
    import wave_pkg::*;
#(
    parameter int PHASE_W   = 24,
    parameter int OUT_W     = 21,
    parameter int AMP_SHIFT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PHASE_W-1:0]       phase,
    input  logic [PHASE_W-1:0]       duty,
    input  logic [MODE_W-1:0]        mode,
    output logic signed [OUT_W-1:0]  sample
);

    localparam int SAW_SH = PHASE_W - 1 - AMP_SHIFT;
    localparam logic signed [OUT_W-1:0] AMP = OUT_W'(1) << AMP_SHIFT;

    logic signed [OUT_W-1:0]   sample_d;
    logic signed [PHASE_W-1:0] saw_centered;

    // Subtracting half the phase range is just an MSB flip.
    assign saw_centered = {~phase[PHASE_W-1], phase[PHASE_W-2:0]};

`ifdef WAVE_SHAPER_TRI_EN
    localparam int TRI_SH = PHASE_W - 2 - AMP_SHIFT;

    logic [PHASE_W-2:0] tri_fold;

    assign tri_fold = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];
`endif

    always_comb begin
        sample_d = '0;
        case (mode_e'(mode))
            MODE_SQUARE: sample_d = (phase <= duty) ? AMP : -AMP;
            MODE_SAW:    sample_d = OUT_W'(saw_centered >>> SAW_SH);
`ifdef WAVE_SHAPER_TRI_EN
            MODE_TRI:    sample_d = OUT_W'(tri_fold >> TRI_SH) - AMP;
`endif
            default:     sample_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
        end else if (in_valid) begin
            sample <= sample_d;
        end
    end

endmodule

// File: rtl/wave_shaper.sv
// Multi-channel waveform shaper with a fixed LATENCY-cycle pipeline.
// Define WAVE_SHAPER_TRI_EN to build triangle mode; otherwise mode 2 yields 0.
module wave_shaper
    import wave_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int PHASE_W   = 24,
    parameter int OUT_W     = 21,
    parameter int AMP_SHIFT = 16,
    parameter int LATENCY   = 7
) (
    input  logic          clk,
    input  logic          rst,
    wave_shaper_if.slave  bus
);

    localparam int SMP_W = N_CH * OUT_W;

    logic [SMP_W-1:0]   lane_smp;
    logic [SMP_W-1:0]   tail_smp;
    logic [LATENCY-2:0] vld;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        wave_shaper_lane #(
            .PHASE_W   (PHASE_W),
            .OUT_W     (OUT_W),
            .AMP_SHIFT (AMP_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_valid (bus.in_valid),
            .phase    (bus.phase[k*PHASE_W +: PHASE_W]),
            .duty     (bus.duty[k*PHASE_W +: PHASE_W]),
            .mode     (bus.mode[k*MODE_W +: MODE_W]),
            .sample   (lane_smp[k*OUT_W +: OUT_W])
        );
    end

    // vld[0] pairs with the lane registers; reset clears every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= bus.in_valid;
            for (int i = 1; i < LATENCY - 1; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    if (LATENCY > 2) begin : g_dly
        logic [SMP_W-1:0] dly [LATENCY-2];

        always_ff @(posedge clk) begin
            dly[0] <= lane_smp;
            for (int i = 1; i < LATENCY - 2; i++) begin
                dly[i] <= dly[i-1];
            end
        end

        assign tail_smp = dly[LATENCY-3];
    end else begin : g_nodly
        assign tail_smp = lane_smp;
    end

    // wave only updates on a valid sample so it stays put between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wave      <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= vld[LATENCY-2];
            if (vld[LATENCY-2]) begin
                bus.wave <= tail_smp;
            end
        end
    end

endmodule

// File: tb/tb_wave_shaper.sv
// Directed, table-driven bench for wave_shaper at default parameters.
// Triangle expectations follow WAVE_SHAPER_TRI_EN.
module tb_wave_shaper;
    import wave_pkg::*;

    localparam int LAT = 7;

    localparam logic [20:0] POS  = 21'h010000;
    localparam logic [20:0] NEG  = 21'h1F0000;
    localparam logic [20:0] MAXP = 21'h00FFFF;
    localparam logic [20:0] ZERO = 21'h000000;

`ifdef WAVE_SHAPER_TRI_EN
    localparam bit TRI_ON = 1'b1;
`else
    localparam bit TRI_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [95:0] phase;
        logic [95:0] duty;
        logic [7:0]  mode;
        logic [83:0] exp_wave;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    wave_shaper_if bus ();

    wave_shaper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] tri_exp(input logic [20:0] v);
        return TRI_ON ? v : ZERO;
    endfunction

    function automatic vec_t mk(input string n, input logic [95:0] p, input logic [95:0] d,
                                input logic [7:0] m, input logic [83:0] e);
        vec_t v;
        v.name = n;
        v.phase = p;
        v.duty = d;
        v.mode = m;
        v.exp_wave = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle input, then wait (bounded) for the strobe and check latency, data and width.
    task automatic applyStimulus(input vec_t v);
        int cyc;
        @(negedge clk);
        bus.phase    = v.phase;
        bus.duty     = v.duty;
        bus.mode     = v.mode;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({v.name, " latency"}, 84'(cyc), 84'(LAT));
        checkOutput({v.name, " wave"}, bus.wave, v.exp_wave);
        @(negedge clk);
        checkOutput({v.name, " strobe width"}, 84'(bus.out_valid), 84'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.phase    = '0;
        bus.duty     = '0;
        bus.mode     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset wave", bus.wave, 84'd0);
        checkOutput("reset out_valid", 84'(bus.out_valid), 84'd0);
        rst = 1'b0;

        vecs.push_back(mk("sq_duty_half",
            {24'hFFFFFF, 24'h000000, 24'h800001, 24'h800000},
            {4{24'h800000}}, 8'h00, {NEG, POS, NEG, POS}));
        vecs.push_back(mk("sq_duty_edges",
            {24'h123456, 24'hFFFFFF, 24'h000001, 24'h000000},
            {24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000}, 8'h00, {POS, POS, NEG, POS}));
        vecs.push_back(mk("saw",
            {24'h400000, 24'hFFFFFF, 24'h800000, 24'h000000},
            96'd0, 8'h55, {21'h1F8000, MAXP, ZERO, NEG}));
        vecs.push_back(mk("tri_a",
            {24'hFFFFFF, 24'h7FFFFF, 24'h400000, 24'h000000},
            96'd0, 8'hAA, {tri_exp(NEG), tri_exp(MAXP), tri_exp(ZERO), tri_exp(NEG)}));
        vecs.push_back(mk("tri_b",
            {24'h000040, 24'h200000, 24'h800000, 24'hC00000},
            96'd0, 8'hAA, {tri_exp(21'h1F0001), tri_exp(21'h1F8000), tri_exp(MAXP), tri_exp(21'h1FFFFF)}));
        vecs.push_back(mk("mixed",
            96'd0, 96'd0, 8'hE4, {ZERO, tri_exp(NEG), NEG, POS}));
        vecs.push_back(mk("reserved",
            {24'h123456, 24'hFFFFFF, 24'h800000, 24'h000001},
            {4{24'h800000}}, 8'hFF, 84'd0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Back-to-back saw ramp: ten inputs, ten consecutive strobes in order.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    bus.phase    = {4{24'(i) << 20}};
                    bus.mode     = 8'h55;
                    bus.in_valid = 1'b1;
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                logic [20:0] e;
                for (int k = 1; k <= 20; k++) begin
                    @(negedge clk);
                    checkOutput($sformatf("ramp valid k=%0d", k), 84'(bus.out_valid),
                                84'(k >= 8 && k <= 17));
                    if (k >= 8 && k <= 17) begin
                        e = 21'((k - 8 - 8) * 8192);
                        checkOutput($sformatf("ramp wave k=%0d", k), bus.wave, {4{e}});
                    end
                end
            end
        join

        // Reset three cycles after an input discards it and clears wave.
        @(negedge clk);
        bus.phase    = {4{24'hFFFFFF}};
        bus.mode     = 8'h55;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("flush valid k=%0d", k), 84'(bus.out_valid), 84'd0);
            checkOutput($sformatf("flush wave k=%0d", k), bus.wave, 84'd0);
            @(negedge clk);
        end

        // in_valid coinciding with rst is ignored.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst+in_valid valid k=%0d", k), 84'(bus.out_valid), 84'd0);
        end

        applyStimulus(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
